// File: rtl/mem_bus_slave_pkg.sv
// mem_bus_slave_pkg: system bus widths and latency helpers shared by the bus slave
package mem_bus_slave_pkg;
  localparam int SYS_ADDR_WIDTH = 16;
  localparam int SYS_DATA_WIDTH = 32;
  typedef logic [3:0] lat_t;
  function automatic lat_t lat_init(input logic we, input int rd_lat, input int wr_lat);
    return we ? lat_t'(wr_lat - 1) : lat_t'(rd_lat - 1);
  endfunction
endpackage

// File: rtl/mem_bus_slave_mem_array.sv
// mem_array: synchronous-write storage with a registered read port that can be cleared
module mem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  // Only the read register is reset; storage contents survive reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata_q <= '0;
    else if (re_i || clr_i) rdata_q <= clr_i ? '0 : mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_bus_slave.sv
// mem_bus_slave: fixed-latency memory bus slave with flush abort and sticky range error
module mem_bus_slave
  import mem_bus_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = SYS_ADDR_WIDTH,
  parameter int DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_oe,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  err
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, DRAIN = 2'd3;
  localparam int IW = $clog2(MEM_DEPTH);
  logic [1:0] state_q, state_d;
  lat_t cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic we_q, err_q, accept, fire, in_range;
  assign accept   = state_q == IDLE && req_valid && !system_flush;
  assign fire     = state_q == ACCESS && cnt_q == '0 && !system_flush;
  assign in_range = 64'(addr_q) < 64'(MEM_DEPTH);
  always_comb begin
    state_d = system_flush      ? IDLE :
              state_q == IDLE   ? (req_valid ? ACCESS : IDLE) :
              state_q == ACCESS ? (cnt_q == '0 ? RESP : ACCESS) :
              state_q == RESP   ? DRAIN : (req_valid ? DRAIN : IDLE);
    cnt_d   = accept ? lat_init(we, RD_LAT, WR_LAT) :
              (state_q == ACCESS && cnt_q != '0) ? cnt_q - lat_t'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (fire && !in_range) err_q <= 1'b1;
    end
  // Out-of-range reads clear the read register instead of aliasing into storage.
  mem_array #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_WIDTH)) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we_i   (fire && we_q && in_range),
    .re_i   (fire && !we_q && in_range),
    .clr_i  (fire && !we_q && !in_range),
    .addr_i (addr_q[IW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );
  assign data_valid = state_q == RESP;
  assign rdata_oe   = data_valid && !we_q;
  assign busy       = state_q != IDLE;
  assign err        = err_q;
endmodule

// File: tb/tb_mem_bus_slave.sv
// tb_mem_bus_slave: randomized scoreboard bench for mem_bus_slave against an array reference model
module tb_mem_bus_slave;
  localparam int RD_LAT = 3, WR_LAT = 2, DEPTH = 256;
  logic clk = 1'b0, reset = 1'b1, system_flush = 1'b0, req_valid = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic rdata_oe, data_valid, busy, err;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {logic w; logic chk; logic [31:0] rd; logic err; int cyc;} exp_t;
  exp_t sbq[$];
  logic [31:0] mem_m [int];
  logic err_m = 1'b0, last_known = 1'b1;
  logic [31:0] last_rd = '0;

  mem_bus_slave #(.MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .reset(reset), .system_flush(system_flush), .req_valid(req_valid),
    .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe),
    .data_valid(data_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint a, input longint x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", n, a, x, cyc);
    end
  endtask

  always @(negedge clk)
    if (!reset && data_valid) begin
      if (sbq.size() == 0) chk("unexpected_data_valid", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("dv_cycle", cyc, e.cyc);
        chk("rdata_oe", longint'(rdata_oe), longint'(!e.w));
        chk("err", longint'(err), longint'(e.err));
        if (e.chk) chk("rdata", longint'(rdata), longint'(e.rd));
      end
    end

  // Model the access outcome first, then drive the bus handshake.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input int hold);
    exp_t e;
    int n;
    if (int'(a) >= DEPTH) err_m = 1'b1;
    if (w && int'(a) < DEPTH) mem_m[int'(a)] = d;
    if (!w) begin
      if (int'(a) >= DEPTH) begin last_rd = '0; last_known = 1'b1; end
      else if (mem_m.exists(int'(a))) begin last_rd = mem_m[int'(a)]; last_known = 1'b1; end
      else last_known = 1'b0;
    end
    e.w = w; e.chk = last_known; e.rd = last_rd; e.err = err_m;
    e.cyc = cyc + 1 + (w ? WR_LAT : RD_LAT);
    sbq.push_back(e);
    req_valid = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    we = ~w; addr = 16'($urandom); wdata = $urandom;
    n = 0;
    while (!data_valid && n < 40) begin @(negedge clk); n++; end
    if (!data_valid) chk("data_valid_timeout", 0, 1);
    chk("busy_resp", longint'(busy), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_drain", longint'(busy), 1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", longint'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_dv", longint'(data_valid), 0);
    chk("rst_oe", longint'(rdata_oe), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_rdata", longint'(rdata), 0);
    reset = 1'b0;
    @(negedge clk);
    issue(1, 16'h0010, 32'hDEADBEEF, 1);
    issue(0, 16'h0010, 32'h0, 4);
    issue(1, 16'h0000, 32'h0BADF00D, 0);
    issue(0, 16'h0100, 32'h0, 1);
    issue(1, 16'h0100, 32'h11111111, 2);
    issue(0, 16'h0000, 32'h0, 1);
    issue(1, 16'h0020, 32'hCAFE0020, 1);
    req_valid = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'h1234;
    @(posedge clk); #1;
    system_flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    system_flush = 1'b0;
    chk("flush_idle", longint'(busy), 0);
    repeat (4) @(negedge clk);
    issue(0, 16'h0020, 32'h0, 1);
    req_valid = 1'b1; system_flush = 1'b1;
    @(negedge clk);
    chk("flush_wins_idle", longint'(busy), 0);
    req_valid = 1'b0; system_flush = 1'b0;
    @(negedge clk);
    issue(1, 16'h0030, 32'h30303030, 1);
    req_valid = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 32'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_dv", longint'(data_valid), 0);
    chk("arst_oe", longint'(rdata_oe), 0);
    chk("arst_err", longint'(err), 0);
    chk("arst_rdata", longint'(rdata), 0);
    err_m = 1'b0; last_rd = '0; last_known = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 16'h0030, 32'h0, 1);
    for (int k = 0; k < 60; k++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_slave.md
MEM_BUS_SLAVE -- requirements
Module: mem_bus_slave

Interface
REQ-001 Parameter: ADDR_WIDTH, `ADDR_WIDTH, bus address width in bits.
REQ-002 Parameter: DATA_WIDTH, `DATA_WIDTH, bus data width in bits.
REQ-003 Parameter: MEM_DEPTH, 256, number of DATA_WIDTH words of backing storage.
REQ-004 Parameter: RD_LAT, 3, read latency in cycles (legal range 1..15).
REQ-005 Parameter: WR_LAT, 2, write latency in cycles (legal range 1..15).
REQ-006 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: system_flush  in  1  synchronous abort of any in-flight access.
REQ-009 Port: req_valid  in  1  request from the upstream arbiter, held high until data_valid has been seen.
REQ-010 Port: addr  in  ADDR_WIDTH  word address.
REQ-011 Port: we  in  1  1 = write, 0 = read.
REQ-012 Port: wdata  in  DATA_WIDTH  write data (the top level resolves the shared bus when we=1).
REQ-013 Port: rdata  out  DATA_WIDTH  read data, valid while data_valid=1.
REQ-014 Port: rdata_oe  out  1  bus drive enable; equals data_valid AND captured we=0.
REQ-015 Port: data_valid  out  1  one-cycle completion pulse for both reads and writes.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: err  out  1  sticky; set on an out-of-range access and cleared only by reset.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP and DRAIN.
REQ-019 IDLE: when req_valid=1, the block SHALL capture addr, we and wdata, load the latency counter with (we ? WR_LAT : RD_LAT)-1, and go to ACCESS.
REQ-020 ACCESS: the counter SHALL decrement each cycle; at 0 the block SHALL perform the access and go to RESP.
REQ-021 data_valid SHALL first be high exactly LAT cycles after the accepting edge, for exactly one cycle (RESP state).
REQ-022 RESP: the block SHALL go to DRAIN unconditionally.
REQ-023 DRAIN: the block SHALL wait for req_valid=0, then go to IDLE; no new request is accepted from DRAIN.
REQ-024 Write: the captured wdata SHALL be stored to mem[addr] on the edge entering RESP.
REQ-025 Read: rdata SHALL be registered from mem[addr] on the edge entering RESP, and SHALL hold that value until the next read completes.
REQ-026 Out-of-range (addr >= MEM_DEPTH): a write SHALL be dropped; a read SHALL return 0; err SHALL be set; data_valid timing SHALL be unchanged.
REQ-027 Captured request fields SHALL NOT change after acceptance, even if the upstream inputs change.
REQ-028 system_flush=1 SHALL force IDLE on the next edge from any state, suppress any pending data_valid and memory write, and leave memory and err unchanged.
REQ-029 If system_flush and req_valid are both high in IDLE, the flush SHALL win and no request is accepted.
REQ-030 The index SHALL be addr[$clog2(MEM_DEPTH)-1:0] after the range check; there is no wrap-around aliasing.

Reset
REQ-031 Reset SHALL force IDLE, counter=0, data_valid=0, rdata_oe=0, busy=0, err=0, rdata=0 and all captured fields=0.
REQ-032 Memory contents SHALL NOT be reset; reads before the first write to a location are undefined, and the bench SHALL NOT check them.
REQ-033 Reset asserted mid-access SHALL abort the access with no write and no data_valid.

Structure
REQ-034 ADDR_WIDTH and DATA_WIDTH SHALL come from system_param.vh.
REQ-035 State encodings SHALL be local parameters of this module.
REQ-036 Storage SHALL be the sub-module mem_array (synchronous write, synchronous registered read, parameterised by DEPTH and WIDTH).

Verification
REQ-037 Write addr=0x10, wdata=0xDEADBEEF, WR_LAT=2 -> data_valid high 2 cycles after accept, rdata_oe=0, busy high from accept until DRAIN exit.
REQ-038 Read addr=0x10 after the write above, RD_LAT=3 -> data_valid and rdata_oe high 3 cycles after accept, rdata=0xDEADBEEF.
REQ-039 req_valid held high 4 cycles past data_valid -> no second access and no second data_valid until req_valid drops and rises again.
REQ-040 Read addr=0x100 with MEM_DEPTH=256 -> rdata=0, err=1 and sticky; write 0x100 then read 0x00 -> 0x00 unchanged.
REQ-041 system_flush one cycle after accepting a write to 0x20 of 0x1234 -> no data_valid, state IDLE next cycle, subsequent read of 0x20 returns its prior value.
REQ-042 Reset pulsed in ACCESS -> all outputs at reset values immediately (asynchronous); the next request completes normally.
